// File: rtl/csat_pkg.sv
// Shared types for the exhaustive CSAT candidate driver: FSM state encoding
// and the result record handed to the consumer.
package csat_pkg;

  // Width the result record is sized for; the driver's NUM_VARS must not exceed it.
  localparam int CSAT_NUM_VARS = 13;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SWEEP  = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_REPORT = 2'd3
  } csat_state_e;

  typedef struct packed {
    logic                     found;
    logic [CSAT_NUM_VARS-1:0] assignment;
    logic [CSAT_NUM_VARS:0]   count;
  } csat_res_t;

endpackage

// File: rtl/csat_enum_driver_if.sv
// Result channel of the CSAT enumeration driver.
// Handshake: res_valid rises when a result is ready and, together with
// res_found/res_assign/res_count, holds steady until a cycle where
// res_valid & res_ready are both high; that cycle completes the transfer.
// res_valid never depends combinationally on res_ready.
interface csat_enum_driver_if
  import csat_pkg::*;
#(
  parameter int NUM_VARS = CSAT_NUM_VARS
);
  logic                res_valid;
  logic                res_ready;
  logic                res_found;
  logic [NUM_VARS-1:0] res_assign;
  logic [NUM_VARS:0]   res_count;

  modport master (
    output res_valid, res_found, res_assign, res_count,
    input  res_ready
  );

  modport slave (
    input  res_valid, res_found, res_assign, res_count,
    output res_ready
  );
endinterface

// File: rtl/csat_tag_pipe.sv
// Fixed-depth tag line: each stage holds an issued candidate and a valid bit,
// so the candidate at the output lines up with the sat answer for it.
module csat_tag_pipe #(
  parameter int W     = 13,
  parameter int DEPTH = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clear_i,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  output logic         any_valid_o
);

  logic [DEPTH-1:0] vld_q;
  logic [W-1:0]     dat_q [DEPTH];

  // Shift one stage per cycle; clear kills every valid bit, including the one entering.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q <= '0;
      for (int i = 0; i < DEPTH; i++) dat_q[i] <= '0;
    end else begin
      vld_q[0] <= in_valid_i & ~clear_i;
      dat_q[0] <= in_data_i;
      for (int i = 1; i < DEPTH; i++) begin
        vld_q[i] <= vld_q[i-1] & ~clear_i;
        dat_q[i] <= dat_q[i-1];
      end
    end
  end

  assign out_valid_o = vld_q[DEPTH-1];
  assign out_data_o  = dat_q[DEPTH-1];
  assign any_valid_o = |vld_q;

endmodule

// File: rtl/csat_enum_driver.sv
// Exhaustive candidate driver for a combinational SAT benchmark: sweeps
// cand_out from 0 to all-ones, matches each sat_in answer to the candidate
// that produced it, and reports the first satisfying assignment (or UNSAT).
module csat_enum_driver
  import csat_pkg::*;
#(
  parameter int NUM_VARS  = CSAT_NUM_VARS,
  parameter int CHECK_LAT = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  output logic [NUM_VARS-1:0] cand_out,
  input  logic                sat_in,
  output logic                busy,
  output csat_state_e         state_dbg,
  csat_enum_driver_if.master  res_bus
);

  logic [1:0]          rst_sync_q;
  logic                rst_int_n;
  csat_state_e         state_q, state_d;
  logic [NUM_VARS-1:0] cand_q, cand_d;
  csat_res_t           res_q, res_d;
  logic                issue, clear_tags;
  logic                tag_valid, tag_any;
  logic [NUM_VARS-1:0] tag_data;
  logic                eval, hit;

  // Reset asserts asynchronously, releases two edges later on a clean clock.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) rst_sync_q <= '0;
    else        rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_int_n = rst_sync_q[1];

  csat_tag_pipe #(
    .W     (NUM_VARS),
    .DEPTH (CHECK_LAT)
  ) u_tags (
    .clk         (clk),
    .rst_n       (rst_int_n),
    .clear_i     (clear_tags),
    .in_valid_i  (issue),
    .in_data_i   (cand_d),
    .out_valid_o (tag_valid),
    .out_data_o  (tag_data),
    .any_valid_o (tag_any)
  );

  // sat_in only means something when the tag leaving the line is valid.
  assign eval = tag_valid && (state_q == ST_SWEEP || state_q == ST_DRAIN);
  assign hit  = eval && sat_in;

  // Next state, next candidate and result record. The line is always empty in
  // IDLE (hits, aborts and drains all leave it empty), so start needs no clear.
  always_comb begin
    state_d    = state_q;
    cand_d     = cand_q;
    res_d      = res_q;
    issue      = 1'b0;
    clear_tags = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_SWEEP;
          cand_d  = '0;
          res_d   = '0;
          issue   = 1'b1;
        end
      end
      ST_SWEEP, ST_DRAIN: begin
        if (eval) res_d.count = res_q.count + (CSAT_NUM_VARS+1)'(1);
        if (hit) begin
          res_d.found      = 1'b1;
          res_d.assignment = CSAT_NUM_VARS'(tag_data);
          state_d          = ST_REPORT;
          clear_tags       = 1'b1;
        end else if (state_q == ST_SWEEP) begin
          cand_d = cand_q + NUM_VARS'(1);
          issue  = 1'b1;
          if (cand_d == '1) state_d = ST_DRAIN;
        end else if (!tag_any) begin
          res_d.found      = 1'b0;
          res_d.assignment = '0;
          state_d          = ST_REPORT;
        end
      end
      ST_REPORT: begin
        if (res_bus.res_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    // Abort beats hit, handshake and start: nothing is issued or captured.
    if (abort) begin
      state_d    = ST_IDLE;
      cand_d     = cand_q;
      res_d      = res_q;
      issue      = 1'b0;
      clear_tags = 1'b1;
    end
  end

  // State, candidate and result registers.
  always_ff @(posedge clk or negedge rst_int_n) begin
    if (!rst_int_n) begin
      state_q <= ST_IDLE;
      cand_q  <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      cand_q  <= cand_d;
      res_q   <= res_d;
    end
  end

  assign cand_out           = cand_q;
  assign busy               = (state_q != ST_IDLE);
  assign state_dbg          = state_q;
  assign res_bus.res_valid  = (state_q == ST_REPORT);
  assign res_bus.res_found  = res_q.found;
  assign res_bus.res_assign = NUM_VARS'(res_q.assignment);
  assign res_bus.res_count  = (NUM_VARS+1)'(res_q.count);

endmodule

// File: doc/csat_enum_driver.md
CSAT_ENUM_DRIVER -- requirements
Module: csat_enum_driver

Interface
REQ-001 SHALL have parameter NUM_VARS, default 13, giving the candidate width (a[7:0] = cand[7:0], b[4:0] = cand[12:8] for 13-input multiplier benchmarks).
REQ-002 SHALL have parameter CHECK_LAT, default 1 (range 1..4), giving the cycles from cand_out change to the matching sat_in sample.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst_n  input  1  asynchronous active-low reset.
REQ-005 start  input  1  one-cycle request to begin a sweep; honoured only in IDLE.
REQ-006 abort  input  1  cancels any sweep or pending result; returns the block to IDLE.
REQ-007 cand_out  output  NUM_VARS  registered assignment driven to the combinational benchmark inputs.
REQ-008 sat_in  input  1  benchmark sat output for the candidate issued CHECK_LAT cycles earlier.
REQ-009 res_valid  output  1  result available.
REQ-010 res_ready  input  1  consumer accepts the result.
REQ-011 res_found  output  1  1 = satisfying assignment found; 0 = exhaustive UNSAT.
REQ-012 res_assign  output  NUM_VARS  satisfying assignment; all zero when res_found=0.
REQ-013 res_count  output  NUM_VARS+1  number of candidates whose sat_in was evaluated.
REQ-014 busy  output  1  high in every state except IDLE.

Function
REQ-015 FSM states SHALL be IDLE, SWEEP, DRAIN and REPORT.
REQ-016 IDLE + start SHALL load cand_out=0, clear res_count and the in-flight tags, and enter SWEEP.
REQ-017 In SWEEP, cand_out SHALL increment by 1 each cycle, and each issued value SHALL enter a CHECK_LAT-deep tag line (value plus valid bit).
REQ-018 sat_in SHALL be considered only when the tag at the output of the tag line is valid; each valid tag SHALL increment res_count.
REQ-019 The first valid tag with sat_in=1 SHALL capture that tag into res_assign, set res_found=1 and enter REPORT; later in-flight tags SHALL be discarded.
REQ-020 Issuing the all-ones candidate SHALL enter DRAIN without wrapping; cand_out SHALL hold all-ones from then on.
REQ-021 DRAIN SHALL evaluate the remaining tags under the rules of REQ-018 and REQ-019; when the line is empty with no hit, it SHALL set res_found=0 and res_assign=0 and enter REPORT.
REQ-022 In REPORT, res_valid SHALL be 1 and res_found, res_assign and res_count SHALL be stable until the res_valid & res_ready cycle; that cycle SHALL return the block to IDLE.
REQ-023 abort in SWEEP, DRAIN or REPORT SHALL enter IDLE on the next edge, deassert res_valid and invalidate all tags; abort SHALL win over a simultaneous hit, handshake or start.
REQ-024 start outside IDLE SHALL be ignored; start and res_ready in the same REPORT cycle SHALL only return to IDLE.
REQ-025 Result latency SHALL be: hit on candidate k gives res_valid exactly k+CHECK_LAT+1 cycles after the start cycle.

Reset
REQ-026 On rst_n=0, state SHALL be IDLE and cand_out, res_valid, res_found, res_assign, res_count, busy and all tags SHALL be 0, immediately and asynchronously.
REQ-027 Release of rst_n SHALL be synchronised internally, so that the first active edge after release is clean; a reset mid-sweep SHALL discard all progress.

Structure
REQ-028 The state enum and the result record (found, assign, count) SHALL be in a shared package, csat_pkg.
REQ-029 The tag line SHALL be one sub-module, csat_tag_pipe, parameterised by width and depth.
REQ-030 The benchmark netlist SHALL be instantiated outside this block, connected only through cand_out and sat_in.

Verification (benchmark multiplier_437_sat, CHECK_LAT=1)
REQ-031 Sweep: start with res_ready=1 -> res_found=1, res_assign=0x1317 (b=19, a=23), res_count=4888, res_valid at cycle 4889.
REQ-032 Backpressure: hold res_ready=0 for 20 cycles after the hit -> res_valid and all result outputs stay constant, then return to IDLE on the accepting cycle.
REQ-033 UNSAT: sat_in tied to 0 -> res_found=0, res_assign=0, res_count=8192, res_valid 8194 cycles after start.
REQ-034 Abort: abort at cycle 100 -> busy=0 next cycle, res_valid never asserts; a new start then gives the same result as REQ-031.
REQ-035 Reset: rst_n low mid-sweep at cycle 3000 -> all outputs 0 asynchronously; start after release gives the result of REQ-031.
REQ-036 Latency: CHECK_LAT=3 with sat_in hard-wired through a 3-stage delay -> same res_assign, with res_valid 2 cycles later than in REQ-031.
